fft256_reorder: RTL
===================

# fft256_reorder

Bit-reversal reorder buffer for the 256-point radix-2² SDF FFT pipeline. It sits after the final FFT stage, which emits each frame's bins in bit-reversed order. It captures each contiguous 256-sample frame into one bank of a ping-pong memory and streams the bins out in natural order (bin 0..255) with a valid/ready handshake. It is the reader-side counterpart of the stage chain's `di_en`/`do_en` streaming interface.

## Interface
- WIDTH, 16, bit width of each real/imag sample (two's complement, passed through unmodified)
- clock  in  1  master clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- di_en  in  1  input enable; high for 256 consecutive cycles per frame
- di_re  in  WIDTH  input sample, real part, bit-reversed order
- di_im  in  WIDTH  input sample, imag part
- do_rdy in  1  downstream ready
- do_en  out 1  output valid
- do_re  out WIDTH  output bin, real part, natural order
- do_im  out WIDTH  output bin, imag part
- do_sof out 1  high with the bin-0 beat of each output frame
- ovf    out 1  one-cycle pulse: an input frame was dropped because no bank was free
- err_partial out 1  one-cycle pulse: `di_en` fell mid-frame and the frame was discarded

## Operation
- Storage is two banks of 256×(2·WIDTH) with synchronous read. Each bank is in one of three states: FREE, FULL or READING.
- **Write counter (`wr_cnt`, 8 bit)**
  - Increments on every cycle with `di_en`=1.
  - On the edge where `di_en`=0: if `wr_cnt`≠0, `wr_cnt` clears to 0, `err_partial` pulses, and the bank stays FREE.
- **Write bank selection**
  - A frame starts when `di_en`=1 and `wr_cnt`=0. At frame start the writer selects the next bank in ping-pong order.
  - If that bank is not FREE, the whole frame is dropped: `ovf` pulses at the start edge, writes are suppressed, and the counter still runs so the frame boundary is tracked.
  - Sample n of an accepted frame is written to address n.
  - On the edge where sample 255 is captured, the bank becomes FULL.
- **Reader FSM**
  - IDLE: waits for a FULL bank (oldest first). It then marks that bank READING, sets `rd_cnt`=0 and goes to READ.
  - READ: reads address bitrev8(`rd_cnt`). The address advances only when the output stage can accept a beat.
  - After address 255 is issued, the bank returns to FREE. If the other bank is FULL at that same edge, the FSM stays in READ on that bank with no gap; otherwise it returns to IDLE.
- **Output stage**
  - A transfer occurs when `do_en` & `do_rdy`.
  - While `do_en`=1 and `do_rdy`=0, `do_en`, `do_re`, `do_im` and `do_sof` hold stable.
  - `do_rdy` has no combinational path to any output. A 2-entry skid absorbs the one-cycle memory latency.
- **Simultaneous events**
  - A write to one bank and a read from the other in the same cycle are always legal.
  - A bank becoming FULL on the same edge the reader finishes the other bank triggers back-to-back streaming.
- **Reset (including mid-frame)**
  - `wr_cnt`, `rd_cnt` and the skid are cleared, both banks go FREE, and the FSM returns to IDLE.
  - Any in-flight output frame is aborted.
  - Memory contents are not cleared.
- Reset values: `do_en`=0, `do_sof`=0, `ovf`=0, `err_partial`=0, `do_re`/`do_im`=0.

## Timing
- Latency: with `do_rdy`=1, `do_en` first rises on the second clock edge after the edge that captured input sample 255.
- Throughput: 1 bin/cycle with `do_rdy` held high. Continuous back-to-back input frames produce gapless output and never raise `ovf`.
- `ovf` and `err_partial` are registered pulses, asserted for exactly one cycle.
- `do_sof` is asserted only on the beat carrying bin 0.

## Configuration
- Macro: `FFT256_REORDER_XCHK_EN`.
- When defined: `do_re`/`do_im` drive {WIDTH{1'bx}} whenever `do_en`=0 and `reset`=0. This makes verification catch consumers that sample invalid data.
- When undefined: `do_re`/`do_im` hold their last value while `do_en`=0.
- Reset behaviour and all other behaviour are identical either way.

## Test plan
- Reset, then one frame with input sample n = (re=n, im=−n) and `do_rdy`=1 → 256 beats with `do_re`=bitrev8(k) and `do_im`=−bitrev8(k) for k=0..255. `do_sof` is high only at k=0. `do_en` rises 2 edges after sample 255 is captured.
- Four back-to-back frames with values offset by 1000·frame index and `do_rdy`=1 → 1024 contiguous `do_en` cycles, each frame correctly reordered, `ovf` never set.
- `do_rdy` held 0 for 300 cycles while 3 frames arrive → frames 1–2 buffered, `ovf` pulses once at the start of frame 3. After `do_rdy`=1, exactly 512 beats are output and frame 3 data never appears.
- `do_rdy` toggled randomly (50%) over 2 frames → beats are held stable while stalled, no beat is lost or duplicated, and the order matches the first test.
- `di_en` dropped after 100 samples → `err_partial` pulses once, there is no output, and the next full frame reorders correctly.
- Reset asserted for 1 cycle at output beat 40 → `do_en`=0 on the next cycle, no further beats, and a subsequent frame is output correctly.

Source files
------------

// File: rtl/fft256_reorder_if.sv
// fft256_reorder_if: input stream, output stream and status pulses of the reorder buffer.
interface fft256_reorder_if #(parameter int WIDTH = 16);
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_rdy;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             do_sof;
  logic             ovf;
  logic             err_partial;
  modport master (output di_en, di_re, di_im, do_rdy, input do_en, do_re, do_im, do_sof, ovf, err_partial);
  modport slave (input di_en, di_re, di_im, do_rdy, output do_en, do_re, do_im, do_sof, ovf, err_partial);
endinterface

// File: rtl/fft256_reorder.sv
// fft256_reorder: bit-reversed to natural-order frame reorder over ping-pong banks, valid/ready output.
// FFT256_REORDER_XCHK_EN: when defined, do_re/do_im are X while do_en is low outside reset.
module fft256_reorder #(parameter int WIDTH = 16) (
  input logic clock,
  input logic reset,
  fft256_reorder_if.slave bus
);
  typedef enum logic [1:0] {FREE, FULL, READING} bank_t;
  typedef enum logic {IDLE, READ} state_t;
  logic [2*WIDTH-1:0] mem [512];
  bank_t bank_st [2];
  state_t state, state_nx;
  logic [7:0] wr_cnt, rd_cnt, rd_addr;
  logic wr_sel, rd_sel, drop_q, ovf_q, err_q;
  logic start, drop_now, drop, we, wr_done;
  logic pop, issue, rd_last, claim, chain;
  logic out_v, out_sof, sp_v, sp_sof;
  logic [2*WIDTH-1:0] out_d, sp_d;
  assign rd_addr = {<<{rd_cnt}};
  assign start = bus.di_en && wr_cnt == 8'd0;
  // A bank released by the reader on this very edge may be claimed at once; this keeps back-to-back frames gapless.
  assign drop_now = !(bank_st[wr_sel] == FREE || (rd_last && rd_sel == wr_sel));
  assign drop = start ? drop_now : drop_q;
  assign we = bus.di_en && !drop;
  assign wr_done = we && wr_cnt == 8'hff;
  assign pop = out_v && bus.do_rdy;
  always_comb begin
    claim = state == IDLE && bank_st[rd_sel] == FULL;
    issue = state == READ && (!sp_v || pop);
    rd_last = issue && rd_cnt == 8'hff;
    chain = rd_last && (bank_st[~rd_sel] == FULL || (wr_done && wr_sel != rd_sel));
    state_nx = claim ? READ : (rd_last && !chain) ? IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock) begin
    if (we) mem[{wr_sel, wr_cnt}] <= {bus.di_re, bus.di_im};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt <= 8'd0;
      rd_cnt <= 8'd0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      drop_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
    end else begin
      wr_cnt <= bus.di_en ? wr_cnt + 8'd1 : 8'd0;
      if (start) drop_q <= drop_now;
      ovf_q <= start && drop_now;
      err_q <= !bus.di_en && wr_cnt != 8'd0;
      if (wr_done) begin
        bank_st[wr_sel] <= FULL;
        wr_sel <= ~wr_sel;
      end
      if (claim) begin
        bank_st[rd_sel] <= READING;
        rd_cnt <= 8'd0;
      end
      if (issue) rd_cnt <= rd_cnt + 8'd1;
      if (rd_last) begin
        bank_st[rd_sel] <= FREE;
        rd_sel <= ~rd_sel;
      end
      if (chain) bank_st[~rd_sel] <= READING;
    end
  end
  // Memory reads land straight in the output register or, if that is occupied and stalled, in the spare entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_v <= 1'b0;
      out_sof <= 1'b0;
      out_d <= '0;
      sp_v <= 1'b0;
      sp_sof <= 1'b0;
      sp_d <= '0;
    end else begin
      if (pop || !out_v) begin
        out_v <= sp_v || issue;
        if (sp_v || issue) {out_sof, out_d} <= sp_v ? {sp_sof, sp_d} : {rd_cnt == 8'd0, mem[{rd_sel, rd_addr}]};
      end
      sp_v <= (pop || !out_v) ? sp_v && issue : sp_v || issue;
      if (issue && (sp_v || (out_v && !pop))) {sp_sof, sp_d} <= {rd_cnt == 8'd0, mem[{rd_sel, rd_addr}]};
    end
  end
  assign bus.do_en = out_v;
  assign bus.do_sof = out_v && out_sof;
  assign bus.ovf = ovf_q;
  assign bus.err_partial = err_q;
`ifdef FFT256_REORDER_XCHK_EN
  assign bus.do_re = (out_v || reset) ? out_d[2*WIDTH-1:WIDTH] : {WIDTH{1'bx}};
  assign bus.do_im = (out_v || reset) ? out_d[WIDTH-1:0] : {WIDTH{1'bx}};
`else
  assign bus.do_re = out_d[2*WIDTH-1:WIDTH];
  assign bus.do_im = out_d[WIDTH-1:0];
`endif
endmodule
